sched_cmd_arbiter: RTL and testbench
====================================

Name: sched_cmd_arbiter

Overview:
- Multi-bank command arbiter between NUM_BANKS per-bank schedulers and the DRAM command path.
- Takes one SCHED_IF-style request bundle per bank (act/rd/wr/pre/ref request plus address, id and len).
- Issues at most one grant per cycle, enforcing inter-bank tRRD/tCCD/tWTR/tRTW with minus-one timing values.
- Registers the winning command onto a single command output.

Parameters:
NUM_BANKS, 4, number of bank requesters (power of two, >=2)
BA_WIDTH, 2, log2(NUM_BANKS)
RA_WIDTH, 16, row address width
CA_WIDTH, 10, column address width
ID_WIDTH, 4, transaction id width
LEN_WIDTH, 4, burst length field width
T_WIDTH, 4, width of each timing input and internal timing counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
act_req  in  NUM_BANKS  per-bank activate request
rd_req  in  NUM_BANKS  per-bank read request
wr_req  in  NUM_BANKS  per-bank write request
pre_req  in  NUM_BANKS  per-bank precharge request
ref_req  in  NUM_BANKS  per-bank refresh request
ra  in  NUM_BANKS*RA_WIDTH  per-bank row address; bank b at [b*RA_WIDTH +: RA_WIDTH]
ca  in  NUM_BANKS*CA_WIDTH  per-bank column address, same packing
id  in  NUM_BANKS*ID_WIDTH  per-bank id, same packing
len  in  NUM_BANKS*LEN_WIDTH  per-bank len, same packing
act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt  out  NUM_BANKS each  per-bank grants, combinational
t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1  in  T_WIDTH each  timing minus one, quasi-static
cmd_valid  out  1  registered command valid
cmd  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
cmd_ba  out  BA_WIDTH  bank of issued command
cmd_ra, cmd_ca, cmd_id, cmd_len  out  RA/CA/ID/LEN_WIDTH  fields of granted bank

Behaviour:
- Grant rules:
  - At most one grant bit asserted across all grant vectors per cycle.
  - A grant is asserted only on a bit whose request is high.
  - Grants are combinational from requests, registered timing counters and the round-robin pointer. No combinational path from timing inputs to grants.
- Class priority: REF > column (RD/WR) > PRE > ACT. The highest class containing an eligible request wins.
- Within a class:
  - Round-robin over banks, search starting at last_ba+1 mod NUM_BANKS.
  - last_ba updates to the granted bank on every grant.
  - Reset value of last_ba is NUM_BANKS-1, so bank 0 is searched first.
- Within a bank, column class: RD preferred over WR when both are high and eligible. Other multi-request combinations resolve by class priority.
- Eligibility:
  - ACT: rrd_cnt==0.
  - RD: ccd_cnt==0 and wtr_cnt==0.
  - WR: ccd_cnt==0 and rtw_cnt==0.
  - PRE and REF: always eligible.
- Counter updates on grant, at the clock edge:
  - ACT loads rrd_cnt<=t_rrd_m1.
  - RD loads ccd_cnt<=t_ccd_m1 and rtw_cnt<=t_rtw_m1.
  - WR loads ccd_cnt<=t_ccd_m1 and wtr_cnt<=t_wtr_m1.
  - Counters not loaded decrement, saturating at 0.
  - Net effect: a grant at cycle T blocks the dependent command until cycle T+t_m1+1. t_m1=0 permits back-to-back issue.
- Output pipeline:
  - Latency 1 cycle: the cycle after a grant, cmd_valid=1 with cmd/cmd_ba and the granted bank's ra/ca/id/len captured at grant.
  - Cycle with no grant: next cycle cmd_valid=0, cmd=0; address fields hold their previous values.
- Requests not granted stay pending. The requester holds its request until granted; the arbiter keeps no per-request state.
- Reset (rst=1 at clock edge), including mid-operation:
  - All timing counters=0, last_ba=NUM_BANKS-1, cmd_valid=0, cmd=0, cmd_ba/ra/ca/id/len=0.
  - All grants forced 0 while rst=1. A command granted in the reset cycle is dropped.
- Timing inputs are sampled only at grant load; changing them mid-count does not alter the running count.
- Idle with no requests: counters decay to 0, pointer unchanged.

Test Plan:
- Reset, then act_req=4'b1111 held with t_rrd_m1=3 -> ACT grants to banks 0,1,2,3 at cycles 0,4,8,12; cmd_valid pulses one cycle after each; cmd=1, cmd_ba=0,1,2,3.
- Bank 1 rd_req and bank 2 act_req together, idle counters -> rd_gnt[1] first; act_gnt[2] next cycle; cmd sequence RD(ba1), ACT(ba2).
- WR on bank 0 at T with t_wtr_m1=5, t_ccd_m1=1, then bank 1 rd_req held -> rd_gnt[1] first at T+6; a WR on bank 2 at T+2 is granted (ccd satisfied, rtw=0).
- RD at T with t_rtw_m1=7, bank 3 wr_req held -> wr_gnt[3] at T+8, not earlier; a pre_req meanwhile is granted at T+1.
- ref_req[2] and rd_req[0] and pre_req[1] together -> ref_gnt[2] first, then rd_gnt[0], then pre_gnt[1], one per cycle.
- rst asserted one cycle after an RD grant with t_ccd_m1=6 -> next cycle cmd_valid=0; after release, a new RD is granted immediately (ccd_cnt cleared).

Source files
------------

// File: rtl/sched_cmd_arbiter.sv
// rtl/sched_cmd_arbiter.sv - multi-bank DRAM command arbiter with inter-bank timing
//
// Picks at most one command per cycle from NUM_BANKS per-bank schedulers and
// registers it onto a single command bus.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   act/rd/wr/pre/ref_req         per-bank request vectors
//   ra, ca, id, len               per-bank fields, bank b at [b*W +: W]
//   act/rd/wr/pre/ref_gnt         per-bank combinational grants (one-hot overall)
//   t_rrd/t_ccd/t_wtr/t_rtw_m1    timing minus one, sampled at grant
//   cmd_valid, cmd, cmd_ba,
//   cmd_ra/ca/id/len              registered issued command
module sched_cmd_arbiter #(
  parameter int NUM_BANKS = 4,
  parameter int BA_WIDTH  = 2,
  parameter int RA_WIDTH  = 16,
  parameter int CA_WIDTH  = 10,
  parameter int ID_WIDTH  = 4,
  parameter int LEN_WIDTH = 4,
  parameter int T_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_BANKS-1:0]           act_req,
  input  logic [NUM_BANKS-1:0]           rd_req,
  input  logic [NUM_BANKS-1:0]           wr_req,
  input  logic [NUM_BANKS-1:0]           pre_req,
  input  logic [NUM_BANKS-1:0]           ref_req,
  input  logic [NUM_BANKS*RA_WIDTH-1:0]  ra,
  input  logic [NUM_BANKS*CA_WIDTH-1:0]  ca,
  input  logic [NUM_BANKS*ID_WIDTH-1:0]  id,
  input  logic [NUM_BANKS*LEN_WIDTH-1:0] len,
  output logic [NUM_BANKS-1:0]           act_gnt,
  output logic [NUM_BANKS-1:0]           rd_gnt,
  output logic [NUM_BANKS-1:0]           wr_gnt,
  output logic [NUM_BANKS-1:0]           pre_gnt,
  output logic [NUM_BANKS-1:0]           ref_gnt,
  input  logic [T_WIDTH-1:0]             t_rrd_m1,
  input  logic [T_WIDTH-1:0]             t_ccd_m1,
  input  logic [T_WIDTH-1:0]             t_wtr_m1,
  input  logic [T_WIDTH-1:0]             t_rtw_m1,
  output logic                           cmd_valid,
  output logic [2:0]                     cmd,
  output logic [BA_WIDTH-1:0]            cmd_ba,
  output logic [RA_WIDTH-1:0]            cmd_ra,
  output logic [CA_WIDTH-1:0]            cmd_ca,
  output logic [ID_WIDTH-1:0]            cmd_id,
  output logic [LEN_WIDTH-1:0]           cmd_len
);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  logic [T_WIDTH-1:0]   rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d, rtw_q, rtw_d;
  logic [BA_WIDTH-1:0]  last_ba_q, last_ba_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [2:0]           cmd_q, cmd_d;
  logic [BA_WIDTH-1:0]  cmd_ba_q, cmd_ba_d;
  logic [RA_WIDTH-1:0]  cmd_ra_q, cmd_ra_d;
  logic [CA_WIDTH-1:0]  cmd_ca_q, cmd_ca_d;
  logic [ID_WIDTH-1:0]  cmd_id_q, cmd_id_d;
  logic [LEN_WIDTH-1:0] cmd_len_q, cmd_len_d;

  logic                 act_ok, rd_ok, wr_ok;
  logic [NUM_BANKS-1:0] col_m, cls_m;
  logic [2:0]           cls_cmd, sel_cmd;
  logic [BA_WIDTH-1:0]  sel_ba, idx;
  logic                 found, gnt_any;

  function automatic logic [T_WIDTH-1:0] dec_sat(input logic [T_WIDTH-1:0] c);
    return (c == '0) ? c : c - T_WIDTH'(1);
  endfunction

  // Eligibility and class selection depend only on registered counters,
  // so timing inputs never reach the grants combinationally.
  always_comb begin
    act_ok  = (rrd_q == '0);
    rd_ok   = (ccd_q == '0) && (wtr_q == '0);
    wr_ok   = (ccd_q == '0) && (rtw_q == '0);
    col_m   = (rd_req & {NUM_BANKS{rd_ok}}) | (wr_req & {NUM_BANKS{wr_ok}});
    cls_m   = '0;
    cls_cmd = CMD_NOP;
    if (|ref_req) begin
      cls_m = ref_req; cls_cmd = CMD_REF;
    end else if (|col_m) begin
      cls_m = col_m;   cls_cmd = CMD_RD;
    end else if (|pre_req) begin
      cls_m = pre_req; cls_cmd = CMD_PRE;
    end else if (|(act_req & {NUM_BANKS{act_ok}})) begin
      cls_m = act_req; cls_cmd = CMD_ACT;
    end

    // Round-robin search from last_ba+1; the final step wraps back to last_ba.
    found  = 1'b0;
    sel_ba = '0;
    idx    = '0;
    for (int i = 1; i <= NUM_BANKS; i++) begin
      idx = last_ba_q + BA_WIDTH'(i);
      if (!found && cls_m[idx]) begin
        found  = 1'b1;
        sel_ba = idx;
      end
    end

    sel_cmd = cls_cmd;
    if (cls_cmd == CMD_RD)
      sel_cmd = (rd_req[sel_ba] && rd_ok) ? CMD_RD : CMD_WR;

    gnt_any = found && !rst;

    act_gnt = '0;
    rd_gnt  = '0;
    wr_gnt  = '0;
    pre_gnt = '0;
    ref_gnt = '0;
    if (gnt_any) begin
      case (sel_cmd)
        CMD_ACT: act_gnt[sel_ba] = 1'b1;
        CMD_RD:  rd_gnt[sel_ba]  = 1'b1;
        CMD_WR:  wr_gnt[sel_ba]  = 1'b1;
        CMD_PRE: pre_gnt[sel_ba] = 1'b1;
        CMD_REF: ref_gnt[sel_ba] = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rrd_d = dec_sat(rrd_q);
    ccd_d = dec_sat(ccd_q);
    wtr_d = dec_sat(wtr_q);
    rtw_d = dec_sat(rtw_q);
    if (gnt_any) begin
      case (sel_cmd)
        CMD_ACT: rrd_d = t_rrd_m1;
        CMD_RD:  begin ccd_d = t_ccd_m1; rtw_d = t_rtw_m1; end
        CMD_WR:  begin ccd_d = t_ccd_m1; wtr_d = t_wtr_m1; end
        default: ;
      endcase
    end
    last_ba_d   = gnt_any ? sel_ba : last_ba_q;
    cmd_valid_d = gnt_any;
    cmd_d       = gnt_any ? sel_cmd : CMD_NOP;
    // Fields hold their last value on idle cycles.
    cmd_ba_d    = gnt_any ? sel_ba : cmd_ba_q;
    cmd_ra_d    = gnt_any ? ra[sel_ba*RA_WIDTH +: RA_WIDTH]    : cmd_ra_q;
    cmd_ca_d    = gnt_any ? ca[sel_ba*CA_WIDTH +: CA_WIDTH]    : cmd_ca_q;
    cmd_id_d    = gnt_any ? id[sel_ba*ID_WIDTH +: ID_WIDTH]    : cmd_id_q;
    cmd_len_d   = gnt_any ? len[sel_ba*LEN_WIDTH +: LEN_WIDTH] : cmd_len_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrd_q       <= '0;
      ccd_q       <= '0;
      wtr_q       <= '0;
      rtw_q       <= '0;
      last_ba_q   <= BA_WIDTH'(NUM_BANKS - 1);
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      cmd_ba_q    <= '0;
      cmd_ra_q    <= '0;
      cmd_ca_q    <= '0;
      cmd_id_q    <= '0;
      cmd_len_q   <= '0;
    end else begin
      rrd_q       <= rrd_d;
      ccd_q       <= ccd_d;
      wtr_q       <= wtr_d;
      rtw_q       <= rtw_d;
      last_ba_q   <= last_ba_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_ra_q    <= cmd_ra_d;
      cmd_ca_q    <= cmd_ca_d;
      cmd_id_q    <= cmd_id_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_ra    = cmd_ra_q;
  assign cmd_ca    = cmd_ca_q;
  assign cmd_id    = cmd_id_q;
  assign cmd_len   = cmd_len_q;

endmodule

// File: tb/tb_sched_cmd_arbiter.sv
// tb/tb_sched_cmd_arbiter.sv - self-checking bench for sched_cmd_arbiter
module tb_sched_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  act_req, rd_req, wr_req, pre_req, ref_req;
  logic [63:0] ra;
  logic [39:0] ca;
  logic [15:0] id;
  logic [15:0] len;
  logic [3:0]  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [3:0]  t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  cmd_ba;
  logic [15:0] cmd_ra;
  logic [9:0]  cmd_ca;
  logic [3:0]  cmd_id;
  logic [3:0]  cmd_len;

  always #5 clk = ~clk;

  sched_cmd_arbiter dut (
    .clk(clk), .rst(rst),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .ra(ra), .ca(ca), .id(id), .len(len),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ba(cmd_ba),
    .cmd_ra(cmd_ra), .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len)
  );

  typedef struct packed {
    logic        v;
    logic [2:0]  c;
    logic [1:0]  ba;
    logic [15:0] ra;
    logic [9:0]  ca;
    logic [3:0]  id;
    logic [3:0]  len;
  } exp_t;

  typedef struct {
    logic [3:0] act, rd, wr, pre, rf;
    logic [2:0] ecmd;
    int         eba;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   checks = 0;
  int   errors = 0;
  exp_t hold;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One arbitration cycle: grants checked before the edge, the registered
  // command is predicted into the scoreboard and compared after the edge.
  task automatic cyc(input logic [2:0] ecmd, input int eba, input string nm);
    logic [19:0] eg;
    exp_t e, got;
    #1;
    eg = '0;
    if (ecmd != 3'd0) eg[(int'(ecmd) - 1) * 4 + eba] = 1'b1;
    check({nm, " gnt"}, {44'd0, ref_gnt, pre_gnt, wr_gnt, rd_gnt, act_gnt}, {44'd0, eg});
    if (rst) begin
      hold = '0;
    end else begin
      hold.v = 1'b0;
      hold.c = 3'd0;
      if (ecmd != 3'd0) begin
        hold.v   = 1'b1;
        hold.c   = ecmd;
        hold.ba  = 2'(eba);
        hold.ra  = 16'h1230 + 16'(eba);
        hold.ca  = 10'h100 + 10'(eba);
        hold.id  = 4'h8 + 4'(eba);
        hold.len = 4'h1 + 4'(eba);
      end
    end
    sb.push_back(hold);
    @(posedge clk);
    #1;
    got = {cmd_valid, cmd, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len};
    e = sb.pop_front();
    check({nm, " cmd"}, {23'd0, got}, {23'd0, e});
  endtask

  task automatic clear_reqs();
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    act_req = '1; ref_req = '1;
    #1;
    check("rst gnt", {44'd0, ref_gnt, pre_gnt, wr_gnt, rd_gnt, act_gnt}, 64'd0);
    @(posedge clk);
    #1;
    check("rst out", {23'd0, cmd_valid, cmd, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len}, 64'd0);
    rst = 1'b0;
    clear_reqs();
    t_rrd_m1 = '0; t_ccd_m1 = '0; t_wtr_m1 = '0; t_rtw_m1 = '0;
    hold = '0;
    sb.delete();
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin
      ra[b*16 +: 16] = 16'h1230 + 16'(b);
      ca[b*10 +: 10] = 10'h100 + 10'(b);
      id[b*4 +: 4]   = 4'h8 + 4'(b);
      len[b*4 +: 4]  = 4'h1 + 4'(b);
    end
    clear_reqs();
    t_rrd_m1 = '0; t_ccd_m1 = '0; t_wtr_m1 = '0; t_rtw_m1 = '0;

    //            act      rd       wr       pre      ref      cmd   ba
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0};
    tbl[1] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd1, 2};
    tbl[2] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd1, 0};
    tbl[3] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 3'd2, 0};
    tbl[4] = '{4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0000, 3'd3, 3};
    tbl[5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 3'd4, 1};
    tbl[6] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 3'd5, 3};
    tbl[7] = '{4'b0011, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 3'd3, 2};
    tbl[8] = '{4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 3'd2, 3};
    tbl[9] = '{4'b1111, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 3'd4, 2};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      act_req = tbl[i].act; rd_req = tbl[i].rd; wr_req = tbl[i].wr;
      pre_req = tbl[i].pre; ref_req = tbl[i].rf;
      cyc(tbl[i].ecmd, tbl[i].eba, $sformatf("vec%0d", i));
      clear_reqs();
    end

    // ACT spacing with tRRD-1 = 3, round-robin across all banks.
    do_reset();
    t_rrd_m1 = 4'd3;
    act_req  = 4'b1111;
    for (int k = 0; k < 13; k++)
      cyc((k % 4 == 0) ? 3'd1 : 3'd0, k / 4, $sformatf("s1 k%0d", k));
    clear_reqs();

    // Column beats activate, then activate follows.
    do_reset();
    rd_req = 4'b0010; act_req = 4'b0100;
    cyc(3'd2, 1, "s2 rd");
    rd_req = '0;
    cyc(3'd1, 2, "s2 act");
    clear_reqs();

    // Write-to-read turnaround blocks reads until T+6.
    do_reset();
    t_wtr_m1 = 4'd5; t_ccd_m1 = 4'd1;
    wr_req = 4'b0001;
    cyc(3'd3, 0, "s3a wr");
    wr_req = '0; rd_req = 4'b0010;
    for (int k = 1; k < 6; k++) cyc(3'd0, 0, $sformatf("s3a T+%0d", k));
    cyc(3'd2, 1, "s3a rd");
    clear_reqs();

    // A write on another bank is allowed at T+2 while the read waits.
    do_reset();
    t_wtr_m1 = 4'd5; t_ccd_m1 = 4'd1;
    wr_req = 4'b0001;
    cyc(3'd3, 0, "s3b wr0");
    wr_req = '0; rd_req = 4'b0010;
    cyc(3'd0, 0, "s3b T+1");
    wr_req = 4'b0100;
    cyc(3'd3, 2, "s3b wr2");
    wr_req = '0;
    cyc(3'd0, 0, "s3b T+3");
    clear_reqs();

    // Read-to-write turnaround; precharge slips in meanwhile.
    do_reset();
    t_rtw_m1 = 4'd7;
    rd_req = 4'b0001;
    cyc(3'd2, 0, "s4 rd");
    rd_req = '0; wr_req = 4'b1000; pre_req = 4'b0010;
    cyc(3'd4, 1, "s4 pre");
    pre_req = '0;
    for (int k = 2; k < 8; k++) cyc(3'd0, 0, $sformatf("s4 T+%0d", k));
    cyc(3'd3, 3, "s4 wr");
    clear_reqs();

    // Class priority, one per cycle.
    do_reset();
    ref_req = 4'b0100; rd_req = 4'b0001; pre_req = 4'b0010;
    cyc(3'd5, 2, "s5 ref");
    ref_req = '0;
    cyc(3'd2, 0, "s5 rd");
    rd_req = '0;
    cyc(3'd4, 1, "s5 pre");
    clear_reqs();

    // Mid-operation reset clears the running tCCD count.
    do_reset();
    t_ccd_m1 = 4'd6;
    rd_req = 4'b0001;
    cyc(3'd2, 0, "s6 rd");
    rst = 1'b1;
    cyc(3'd0, 0, "s6 rst");
    rst = 1'b0;
    cyc(3'd2, 0, "s6 rd2");
    clear_reqs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
